systolic_feed_sequencer: RTL and testbench

//  Hardware producer for the systolic_array input interface: accepts integer z-vectors over a

---
 rtl/systolic_feed_sequencer.sv | 174 +++++++++++++++++
 tb/tb_systolic_feed_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feed_sequencer
// Description : Streams integer z-vectors into a systolic array as fixed-point
//               rows with per-row control, sequences layers, drains, signals done.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feed_sequencer #(
    parameter int DATA_SIZE      = 16,
    parameter int SIZE           = 3,
    parameter int MAX_LAYER_SIZE = 5,
    parameter int FRAC_BITS      = DATA_SIZE / 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               num_layers,
    input  logic [DATA_SIZE*SIZE-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_SIZE*SIZE-1:0] z_to_z,
    output logic                      reset_counter_in,
    output logic [31:0]               address,
    output logic [SIZE-1:0]           one_address,
    output logic [SIZE-1:0]           output_replace_pattern,
    output logic [31:0]               current_layer,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // The array pipeline needs 2*SIZE-1 empty cycles to flush the last row.
    localparam int                 c_cnt_w      = (2 * SIZE > 1) ? $clog2(2 * SIZE) : 1;
    localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(2 * SIZE - 2);

    state_t               r_state;
    logic [31:0]          r_row;
    logic [31:0]          r_layer;
    logic [31:0]          r_num_layers;
    logic [c_cnt_w-1:0]   r_drain_cnt;

    logic [DATA_SIZE*SIZE-1:0] w_conv;
    logic [SIZE-1:0]           w_lane_ovf;
    logic [SIZE-1:0]           w_onehot;
    logic                      w_beat;
    logic                      w_cfg_ok;
    logic                      w_last_row;
    logic                      w_last_layer;

    // Each lane is shifted into fixed point; it overflows when the bits shifted
    // out plus the new sign bit disagree with the original sign.
    for (genvar g = 0; g < SIZE; g++) begin : g_lane
        localparam int c_hi = (SIZE - g) * DATA_SIZE - 1;
        logic [DATA_SIZE-1:0] w_lane;
        logic [FRAC_BITS:0]   w_top;

        assign w_lane = in_data[c_hi -: DATA_SIZE];
        assign w_top  = w_lane[DATA_SIZE-1 -: FRAC_BITS+1];
        assign w_conv[c_hi -: DATA_SIZE] = {w_lane[DATA_SIZE-FRAC_BITS-1:0], {FRAC_BITS{1'b0}}};
        assign w_lane_ovf[g] = (|w_top) & ~(&w_top);
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < SIZE; i++) begin
            w_onehot[i] = (r_row == 32'(i));
        end
    end

    assign w_beat       = in_valid & in_ready;
    assign w_cfg_ok     = (num_layers != 32'd0) && (num_layers <= 32'(MAX_LAYER_SIZE));
    assign w_last_row   = (r_row == 32'(SIZE - 1));
    assign w_last_layer = (r_layer == r_num_layers - 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state                <= S_IDLE;
            r_row                  <= '0;
            r_layer                <= '0;
            r_num_layers           <= '0;
            r_drain_cnt            <= '0;
            in_ready               <= 1'b0;
            z_to_z                 <= '0;
            reset_counter_in       <= 1'b0;
            address                <= '0;
            one_address            <= '0;
            output_replace_pattern <= '0;
            current_layer          <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            overflow               <= 1'b0;
            cfg_err                <= 1'b0;
        end else begin
            // Bubble by default; only an accepted beat issues a row.
            z_to_z                 <= '0;
            one_address            <= '0;
            output_replace_pattern <= '0;
            reset_counter_in       <= 1'b0;
            done                   <= 1'b0;
            cfg_err                <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_num_layers <= num_layers;
                            r_row        <= '0;
                            r_layer      <= '0;
                            overflow     <= 1'b0;
                            in_ready     <= 1'b1;
                            busy         <= 1'b1;
                            r_state      <= S_FEED;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end

                S_FEED: begin
                    if (w_beat) begin
                        z_to_z                 <= w_conv;
                        address                <= r_row;
                        current_layer          <= r_layer;
                        one_address            <= w_onehot;
                        reset_counter_in       <= (r_row == 32'd0);
                        output_replace_pattern <= (r_row == 32'd0) ? {SIZE{1'b1}} : {SIZE{1'b0}};
                        overflow               <= overflow | (|w_lane_ovf);

                        if (w_last_row) begin
                            r_row <= '0;
                            if (w_last_layer) begin
                                in_ready    <= 1'b0;
                                r_drain_cnt <= '0;
                                r_state     <= S_DRAIN;
                            end else begin
                                r_layer <= r_layer + 32'd1;
                            end
                        end else begin
                            r_row <= r_row + 32'd1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (r_drain_cnt == c_drain_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feed_sequencer
// Description : Directed self-checking bench for systolic_feed_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feed_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] num_layers;
    logic [47:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] z_to_z;
    logic        reset_counter_in;
    logic [31:0] address;
    logic [2:0]  one_address;
    logic [2:0]  output_replace_pattern;
    logic [31:0] current_layer;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    systolic_feed_sequencer #(
        .DATA_SIZE(16), .SIZE(3), .MAX_LAYER_SIZE(5), .FRAC_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_layers(num_layers),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .z_to_z(z_to_z), .reset_counter_in(reset_counter_in), .address(address),
        .one_address(one_address), .output_replace_pattern(output_replace_pattern),
        .current_layer(current_layer), .busy(busy), .done(done),
        .overflow(overflow), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            step();
            seen = done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%0b required 1 within 30 cycles", name, done);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_layers = 32'd0; in_data = '0; in_valid = 1'b0;
        step(); step();
        checks++;
        if ({in_ready, z_to_z, reset_counter_in, address, one_address, output_replace_pattern,
             current_layer, busy, done, overflow, cfg_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: z=%h addr=%0d busy=%b in_ready=%b required all 0",
                     z_to_z, address, busy, in_ready);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_run();
        num_layers = 32'd2; in_data = 48'h0001_0002_0003; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: busy=%b in_ready=%b required 1 1", busy, in_ready);
        end
        in_valid = 1'b1;
        for (int r = 0; r < 6; r++) begin
            step();
            checks++;
            if (z_to_z !== 48'h0100_0200_0300 || address !== 32'(r % 3) ||
                current_layer !== 32'(r / 3) || one_address !== 3'(1 << (r % 3)) ||
                reset_counter_in !== (r % 3 == 0) ||
                output_replace_pattern !== ((r % 3 == 0) ? 3'b111 : 3'b000)) begin
                errors++;
                $display("FAIL basic_row%0d: z=%h addr=%0d layer=%0d one=%b rci=%b orp=%b required z=010002000300 addr=%0d layer=%0d",
                         r, z_to_z, address, current_layer, one_address, reset_counter_in,
                         output_replace_pattern, r % 3, r / 3);
            end
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_drain_entry: in_ready=%b busy=%b required 0 1", in_ready, busy);
        end
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (done !== (c == 5) || busy !== (c != 5)) begin
                errors++;
                $display("FAIL basic_drain_c%0d: done=%b busy=%b required %b %b",
                         c, done, busy, c == 5, c != 5);
            end
            if (c == 1) begin
                checks++;
                if (z_to_z !== '0 || one_address !== 3'b000 || address !== 32'd2 ||
                    current_layer !== 32'd1 || reset_counter_in !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_drain_bubble: z=%h one=%b addr=%0d layer=%0d required 0 000 2 1",
                             z_to_z, one_address, address, current_layer);
                end
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_valid_toggle();
        num_layers = 32'd1; in_data = 48'h0001_0002_0003; start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; step();
        checks++;
        if (address !== 32'd0 || one_address !== 3'b001) begin
            errors++;
            $display("FAIL toggle_row0: addr=%0d one=%b required 0 001", address, one_address);
        end
        in_valid = 1'b0; step();
        checks++;
        if (one_address !== 3'b000 || z_to_z !== '0 || address !== 32'd0 ||
            reset_counter_in !== 1'b0 || output_replace_pattern !== 3'b000) begin
            errors++;
            $display("FAIL toggle_bubble: one=%b z=%h addr=%0d rci=%b orp=%b required 000 0 0 0 000",
                     one_address, z_to_z, address, reset_counter_in, output_replace_pattern);
        end
        in_valid = 1'b1; step();
        checks++;
        if (address !== 32'd1 || one_address !== 3'b010 || output_replace_pattern !== 3'b000 ||
            z_to_z !== 48'h0100_0200_0300) begin
            errors++;
            $display("FAIL toggle_row1: addr=%0d one=%b orp=%b z=%h required 1 010 000 010002000300",
                     address, one_address, output_replace_pattern, z_to_z);
        end
        wait_done("toggle");
    endtask

    task automatic test_overflow();
        num_layers = 32'd1; start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 48'hFFFF_0000_0000; step();
        checks++;
        if (z_to_z !== 48'hFF00_0000_0000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_neg1: z=%h ovf=%b required ff0000000000 0", z_to_z, overflow);
        end
        in_data = 48'h0000_00C8_0000; step();
        checks++;
        if (z_to_z !== 48'h0000_C800_0000 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_200: z=%h ovf=%b required 0000c8000000 1", z_to_z, overflow);
        end
        in_data = 48'h0001_0002_0003; step();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b required 1", overflow);
        end
        wait_done("ovf");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_idle_hold: ovf=%b required 1", overflow);
        end
    endtask

    task automatic test_cfg_err();
        logic [31:0] bad [2];
        bad[0] = 32'd0; bad[1] = 32'd6;
        for (int b = 0; b < 2; b++) begin
            num_layers = bad[b]; start = 1'b1;
            step();
            start = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_n%0d: cfg_err=%b busy=%b in_ready=%b required 1 0 0",
                         bad[b], cfg_err, busy, in_ready);
            end
            step();
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_pulse_n%0d: cfg_err=%b busy=%b required 0 0", bad[b], cfg_err, busy);
            end
        end
        num_layers = 32'd1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_clears_ovf: ovf=%b busy=%b required 0 1", overflow, busy);
        end
        in_valid = 1'b1;
        wait_done("cfg_legal");
    endtask

    task automatic test_reset_midrun();
        logic seen;
        num_layers = 32'd2; in_data = 48'h0001_0002_0003; start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        for (int r = 0; r < 5; r++) step();
        checks++;
        if (address !== 32'd1 || current_layer !== 32'd1) begin
            errors++;
            $display("FAIL midrun_pos: addr=%0d layer=%0d required 1 1", address, current_layer);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if ({in_ready, z_to_z, reset_counter_in, address, one_address, output_replace_pattern,
             current_layer, busy, done, overflow, cfg_err} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: z=%h addr=%0d layer=%0d busy=%b in_ready=%b required all 0",
                     z_to_z, address, current_layer, busy, in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            seen = seen | done | busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: done_or_busy_seen=%b required 0", seen);
        end
        num_layers = 32'd1; start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b1;
        step();
        checks++;
        if (current_layer !== 32'd0 || address !== 32'd0 || reset_counter_in !== 1'b1 ||
            z_to_z !== 48'h0100_0200_0300) begin
            errors++;
            $display("FAIL midrun_restart: layer=%0d addr=%0d rci=%b z=%h required 0 0 1 010002000300",
                     current_layer, address, reset_counter_in, z_to_z);
        end
        wait_done("restart");
    endtask

    task automatic test_start_while_busy();
        int  rows;
        logic seen;
        num_layers = 32'd3; in_data = 48'h0001_0002_0003; start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b1;
        rows = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (c == 2) begin
                start = 1'b1; num_layers = 32'd1;
            end else begin
                start = 1'b0;
            end
            step();
            if (one_address != 3'b000) rows++;
            seen = done;
        end
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (rows !== 9 || seen !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_rows: rows=%0d done_seen=%b required 9 1", rows, seen);
        end
        checks++;
        if (current_layer !== 32'd2 || address !== 32'd2) begin
            errors++;
            $display("FAIL busy_start_last: layer=%0d addr=%0d required 2 2", current_layer, address);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_valid_toggle();
        test_overflow();
        test_cfg_err();
        test_reset_midrun();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
